// File: rtl/tdsp_multi_bus_mach.sv
`default_nettype none
// ============================================================================
// tdsp_multi_bus_mach : NCH-client round-robin bus machine over one shared external bus
// Revision 1.0
// ============================================================================
module tdsp_multi_bus_mach #(
  parameter int NCH     = 3,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int SYNC_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic [NCH-1:0]    go,
  input  logic [NCH-1:0]    read_cycle,
  input  logic [NCH*AW-1:0] addrs_in,
  input  logic [NCH*DW-1:0] data_out,
  input  logic [3:0]        wait_states,
  output logic [DW-1:0]     data_in,
  output logic [NCH-1:0]    done,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic              as,
  output logic              read,
  output logic              write,
  output logic              write_h,
  output logic [AW-1:0]     address,
  input  logic [DW-1:0]     pad_data_in,
  output logic [DW-1:0]     pad_data_out
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ADDR = 3'd2,
    S_WAIT = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t         state;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] cand;
  logic [NCH-1:0] win_oh;
  logic [NCH-1:0] cur_oh;
  logic [CW-1:0]  last;
  logic [CW-1:0]  win;
  logic [CW-1:0]  idx_c;
  logic           found;
  logic           arb_go;
  logic [AW-1:0]  sel_addr;
  logic [AW-1:0]  cur_addr;
  logic [DW-1:0]  sel_wdata;
  logic [DW-1:0]  cur_wdata;
  logic           sel_dir;
  logic           cur_dir;
  logic [3:0]     cnt;
  int             idx;

  assign cand   = pend | go;
  assign arb_go = found && (sync || (SYNC_EN == 0));

  // Round-robin search begins just after the previous winner and wraps.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = 0;
    idx_c = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx   = (int'(last) + k) % NCH;
      idx_c = idx[CW-1:0];
      if (!found && cand[idx_c]) begin
        found = 1'b1;
        win   = idx_c;
      end
    end
  end

  always_comb begin
    win_oh    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_dir   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (win == i[CW-1:0]) begin
        win_oh[i] = 1'b1;
        sel_addr  = addrs_in[i*AW +: AW];
        sel_wdata = data_out[i*DW +: DW];
        sel_dir   = read_cycle[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pend         <= '0;
      last         <= CW'(NCH - 1);
      cur_oh       <= '0;
      cur_addr     <= '0;
      cur_wdata    <= '0;
      cur_dir      <= 1'b0;
      cnt          <= '0;
      done         <= '0;
      bus_request  <= 1'b0;
      as           <= 1'b0;
      read         <= 1'b0;
      write        <= 1'b0;
      write_h      <= 1'b0;
      address      <= '0;
      pad_data_out <= '0;
      data_in      <= '0;
    end else begin
      done <= '0;
      pend <= cand;
      case (state)
        S_IDLE: begin
          if (arb_go) begin
            // A go on the winning channel in this same cycle is absorbed.
            pend        <= cand & ~win_oh;
            last        <= win;
            cur_oh      <= win_oh;
            cur_addr    <= sel_addr;
            cur_wdata   <= sel_wdata;
            cur_dir     <= sel_dir;
            bus_request <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_grant) begin
            as           <= 1'b1;
            read         <= cur_dir;
            write        <= !cur_dir;
            address      <= cur_addr;
            pad_data_out <= cur_wdata;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          as <= 1'b0;
          if (wait_states != 4'd0) begin
            cnt   <= wait_states;
            state <= S_WAIT;
          end else begin
            write   <= 1'b0;
            write_h <= !cur_dir;
            state   <= S_DATA;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            write   <= 1'b0;
            write_h <= !cur_dir;
            state   <= S_DATA;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DATA: begin
          if (cur_dir) begin
            data_in <= pad_data_in;
          end
          read    <= 1'b0;
          write_h <= 1'b0;
          done    <= cur_oh;
          state   <= S_DONE;
        end
        S_DONE: begin
          bus_request <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdsp_multi_bus_mach.sv
`default_nettype none
// ============================================================================
// tb_tdsp_multi_bus_mach : scenario tasks plus a randomized timeline scoreboard
// Revision 1.0
// ============================================================================
module tb_tdsp_multi_bus_mach;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int MAXC = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              sync;
  logic [NCH-1:0]    go;
  logic [NCH-1:0]    read_cycle;
  logic [NCH*AW-1:0] addrs_in;
  logic [NCH*DW-1:0] data_out;
  logic [3:0]        wait_states;
  logic [DW-1:0]     data_in;
  logic [NCH-1:0]    done;
  logic              bus_request;
  logic              bus_grant;
  logic              as;
  logic              read;
  logic              write;
  logic              write_h;
  logic [AW-1:0]     address;
  logic [DW-1:0]     pad_data_in;
  logic [DW-1:0]     pad_data_out;
  logic [DW-1:0]     pad_fixed;
  logic              use_fixed;

  int total = 0;
  int bad   = 0;

  // Memory stand-in: a fixed word, or a value derived from the bus address.
  assign pad_data_in = use_fixed ? pad_fixed : (address ^ 16'hC3A5);

  tdsp_multi_bus_mach #(.NCH(NCH), .AW(AW), .DW(DW), .SYNC_EN(1)) dut (
    .clk(clk), .reset(reset), .sync(sync), .go(go), .read_cycle(read_cycle),
    .addrs_in(addrs_in), .data_out(data_out), .wait_states(wait_states),
    .data_in(data_in), .done(done), .bus_request(bus_request), .bus_grant(bus_grant),
    .as(as), .read(read), .write(write), .write_h(write_h), .address(address),
    .pad_data_in(pad_data_in), .pad_data_out(pad_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go    = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({done, bus_request, as, read, write, write_h, address, pad_data_out, data_in} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got done=%b req=%b as=%b rd=%b wr=%b wh=%b addr=%h pdo=%h din=%h exp all zero",
               done, bus_request, as, read, write, write_h, address, pad_data_out, data_in);
    end
  endtask

  task automatic test_single_read();
    logic [NCH-1:0] edone;
    do_reset();
    use_fixed = 1'b1;
    pad_fixed = 16'hBEEF;
    wait_states = 4'd0;
    addrs_in[1*AW +: AW] = 16'h0040;
    read_cycle = 3'b010;
    go = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      tick();
      go = '0;
      edone = (c == 4) ? 3'b010 : 3'b000;
      total++;
      if (as !== (c == 2)) begin bad++; $display("FAIL rd_as c=%0d got=%b exp=%b", c, as, (c == 2)); end
      total++;
      if (bus_request !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL rd_req c=%0d got=%b", c, bus_request); end
      total++;
      if (done !== edone) begin bad++; $display("FAIL rd_done c=%0d got=%b exp=%b", c, done, edone); end
      if (c == 2 || c == 3) begin
        total++;
        if (read !== 1'b1 || write !== 1'b0) begin bad++; $display("FAIL rd_strobe c=%0d got rd=%b wr=%b exp rd=1 wr=0", c, read, write); end
      end
      if (c == 2) begin
        total++;
        if (address !== 16'h0040) begin bad++; $display("FAIL rd_addr got=%h exp=0040", address); end
      end
    end
    total++;
    if (data_in !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", data_in); end
  endtask

  task automatic test_write_wait();
    logic [NCH-1:0] edone;
    do_reset();
    wait_states = 4'd3;
    addrs_in[0 +: AW] = 16'h0012;
    data_out[0 +: DW] = 16'h5A5A;
    read_cycle = 3'b000;
    go = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      go = '0;
      if (c == 1) begin
        addrs_in[0 +: AW] = 16'hFFFF;
        data_out[0 +: DW] = 16'h0000;
      end
      edone = (c == 7) ? 3'b001 : 3'b000;
      total++;
      if (write !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL wr_write c=%0d got=%b", c, write); end
      total++;
      if (write_h !== (c == 6)) begin bad++; $display("FAIL wr_hold c=%0d got=%b", c, write_h); end
      total++;
      if (done !== edone) begin bad++; $display("FAIL wr_done c=%0d got=%b exp=%b", c, done, edone); end
      if (c >= 2) begin
        total++;
        if (pad_data_out !== 16'h5A5A || address !== 16'h0012) begin
          bad++; $display("FAIL wr_bus c=%0d got pdo=%h addr=%h exp pdo=5a5a addr=0012", c, pad_data_out, address);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NCH-1:0] edone;
    do_reset();
    wait_states = 4'd0;
    read_cycle = 3'b111;
    use_fixed = 1'b0;
    for (int i = 0; i < NCH; i++) addrs_in[i*AW +: AW] = 16'(16'h0100 + i);
    go = 3'b111;
    for (int c = 1; c <= 16; c++) begin
      tick();
      go = '0;
      edone = (c >= 4 && (c - 4) % 5 == 0 && (c - 4) / 5 < NCH) ? 3'(1 << ((c - 4) / 5)) : 3'b000;
      total++;
      if (done !== edone) begin bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, edone); end
      if (c >= 2 && (c - 2) % 5 == 0 && (c - 2) / 5 < NCH) begin
        total++;
        if (as !== 1'b1 || address !== 16'(16'h0100 + (c - 2) / 5)) begin
          bad++; $display("FAIL b2b_addr c=%0d got as=%b addr=%h exp %h", c, as, address, 16'(16'h0100 + (c - 2) / 5));
        end
      end
    end
  endtask

  task automatic test_grant_stall();
    int got_c;
    logic [NCH-1:0] got_done;
    do_reset();
    bus_grant = 1'b0;
    wait_states = 4'd2;
    read_cycle = 3'b000;
    addrs_in[2*AW +: AW] = 16'h0777;
    data_out[2*DW +: DW] = 16'h1357;
    go = 3'b100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      go = '0;
      total++;
      if (bus_request !== 1'b1 || as !== 1'b0) begin
        bad++; $display("FAIL gnt_stall c=%0d got req=%b as=%b exp req=1 as=0", c, bus_request, as);
      end
    end
    bus_grant = 1'b1;
    tick();
    total++;
    if (as !== 1'b1) begin bad++; $display("FAIL gnt_as got=%b exp=1", as); end
    bus_grant = 1'b0;
    got_c = 0;
    got_done = '0;
    for (int c = 12; c <= 24; c++) begin
      tick();
      if (done !== 3'b000 && got_c == 0) begin
        got_c = c;
        got_done = done;
      end
    end
    total++;
    if (got_c != 15 || got_done !== 3'b100) begin
      bad++; $display("FAIL gnt_drop_done got cycle=%0d done=%b exp cycle=15 done=100", got_c, got_done);
    end
    bus_grant = 1'b1;
  endtask

  task automatic test_sync_gate();
    int phase, g0, req_c;
    logic ereq;
    for (int rep = 0; rep < 3; rep++) begin
      sync = 1'b1;
      do_reset();
      wait_states = 4'd0;
      read_cycle = 3'b010;
      phase = $urandom_range(0, 5);
      g0 = $urandom_range(0, 5);
      req_c = g0;
      while (req_c % 6 != phase) req_c++;
      req_c = req_c + 1;
      for (int t = 0; t < 24; t++) begin
        sync = (t % 6 == phase);
        go = (t == g0) ? 3'b010 : 3'b000;
        tick();
        ereq = (t + 1 >= req_c) && (t + 1 <= req_c + 3);
        total++;
        if (bus_request !== ereq) begin
          bad++; $display("FAIL sync_req rep=%0d c=%0d got=%b exp=%b", rep, t + 1, bus_request, ereq);
        end
      end
    end
    sync = 1'b1;
    go = '0;
  endtask

  task automatic test_reset_mid();
    logic [NCH-1:0] edone;
    do_reset();
    use_fixed = 1'b1;
    pad_fixed = 16'hBEEF;
    wait_states = 4'd0;
    read_cycle = 3'b001;
    addrs_in[0 +: AW] = 16'h0033;
    go = 3'b001;
    for (int c = 1; c <= 5; c++) begin tick(); go = '0; end
    wait_states = 4'd5;
    read_cycle = 3'b000;
    data_out[0 +: DW] = 16'h1234;
    go = 3'b001;
    for (int c = 1; c <= 4; c++) begin tick(); go = '0; end
    total++;
    if (write !== 1'b1) begin bad++; $display("FAIL mid_wait_write got=%b exp=1", write); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({done, bus_request, as, read, write, write_h, address, pad_data_out, data_in} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got done=%b req=%b as=%b rd=%b wr=%b wh=%b addr=%h pdo=%h din=%h exp all zero",
               done, bus_request, as, read, write, write_h, address, pad_data_out, data_in);
    end
    wait_states = 4'd0;
    read_cycle = 3'b100;
    pad_fixed = 16'h7777;
    addrs_in[2*AW +: AW] = 16'h0222;
    go = 3'b100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      go = '0;
      edone = (c == 4) ? 3'b100 : 3'b000;
      total++;
      if (done !== edone) begin bad++; $display("FAIL mid_fresh_done c=%0d got=%b exp=%b", c, done, edone); end
    end
    total++;
    if (data_in !== 16'h7777) begin bad++; $display("FAIL mid_fresh_data got=%h exp=7777", data_in); end
  endtask

  // Timeline model: an access won at cycle t puts the address out at t+2,
  // completes at t+4+W and frees the bus for arbitration at t+5+W.
  task automatic test_random();
    logic [NCH-1:0] e_done [MAXC];
    logic           e_as   [MAXC];
    logic [AW-1:0]  e_addr [MAXC];
    logic           e_rd   [MAXC];
    logic [DW-1:0]  e_wd   [MAXC];
    logic [NCH-1:0] mpend, cand;
    int W, t, free_at, mlast, w, idx;
    logic [AW-1:0]  a;
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < MAXC; i++) begin
        e_done[i] = '0; e_as[i] = 1'b0; e_addr[i] = '0; e_rd[i] = 1'b0; e_wd[i] = '0;
      end
      sync = 1'b1;
      bus_grant = 1'b1;
      use_fixed = 1'b0;
      do_reset();
      W = $urandom_range(0, 3);
      wait_states = 4'(W);
      mpend = '0;
      mlast = NCH - 1;
      free_at = 0;
      t = 0;
      while (t < 400) begin
        go = (t < 80 && $urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        for (int i = 0; i < NCH; i++) begin
          addrs_in[i*AW +: AW] = 16'($urandom);
          data_out[i*DW +: DW] = 16'($urandom);
        end
        read_cycle = 3'($urandom);
        cand = mpend | go;
        if (t >= free_at && cand != '0) begin
          w = -1;
          for (int k = 1; k <= NCH; k++) begin
            idx = (mlast + k) % NCH;
            if (w < 0 && cand[idx]) w = idx;
          end
          mpend = cand & ~3'(1 << w);
          mlast = w;
          e_as[t+2]   = 1'b1;
          e_addr[t+2] = addrs_in[w*AW +: AW];
          e_rd[t+2]   = read_cycle[w];
          e_wd[t+2]   = data_out[w*DW +: DW];
          e_done[t+4+W] = 3'(1 << w);
          e_rd[t+4+W] = read_cycle[w];
          e_addr[t+4+W] = addrs_in[w*AW +: AW];
          free_at = t + 5 + W;
        end else begin
          mpend = cand;
        end
        tick();
        t++;
        total++;
        if (done !== e_done[t]) begin bad++; $display("FAIL rnd_done run=%0d c=%0d got=%b exp=%b", run, t, done, e_done[t]); end
        total++;
        if (as !== e_as[t]) begin bad++; $display("FAIL rnd_as run=%0d c=%0d got=%b exp=%b", run, t, as, e_as[t]); end
        if (e_as[t]) begin
          total++;
          if (address !== e_addr[t] || read !== e_rd[t] || write !== !e_rd[t]) begin
            bad++; $display("FAIL rnd_addr run=%0d c=%0d got addr=%h rd=%b wr=%b exp addr=%h rd=%b",
                            run, t, address, read, write, e_addr[t], e_rd[t]);
          end
          if (!e_rd[t]) begin
            total++;
            if (pad_data_out !== e_wd[t]) begin bad++; $display("FAIL rnd_wdata run=%0d c=%0d got=%h exp=%h", run, t, pad_data_out, e_wd[t]); end
          end
        end
        if (e_done[t] != '0 && e_rd[t]) begin
          a = e_addr[t] ^ 16'hC3A5;
          total++;
          if (data_in !== a) begin bad++; $display("FAIL rnd_rdata run=%0d c=%0d got=%h exp=%h", run, t, data_in, a); end
        end
        if (t >= 80 && mpend == '0 && t >= free_at) break;
      end
    end
    go = '0;
  endtask

  initial begin
    reset = 1'b1;
    sync = 1'b1;
    go = '0;
    read_cycle = '0;
    addrs_in = '0;
    data_out = '0;
    wait_states = '0;
    bus_grant = 1'b1;
    pad_fixed = '0;
    use_fixed = 1'b1;
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_grant_stall();
    test_sync_gate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
